// File: rtl/iq_pkg.sv
// Shared widths, source indices and the per-source state record for the issue queue.
package iq_pkg;
    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned TAG_W_DEF  = 6;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned PAY_W_DEF  = 106;
    localparam int unsigned NUM_BC_DEF = 2;
    localparam int unsigned NUM_W_DEF  = 32;

    localparam int unsigned NUM_SRC = 3;
    localparam int unsigned SRC_A   = 0;
    localparam int unsigned SRC_B   = 1;
    localparam int unsigned SRC_C   = 2;

    typedef struct packed {
        logic                  rdy;
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] val;
    } src_state_t;
endpackage

// File: rtl/issue_queue_param_if.sv
// Rename/enqueue, result broadcast and issue bundle of the issue queue.
interface issue_queue_param_if
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PAY_W  = PAY_W_DEF,
    parameter int unsigned NUM_BC = NUM_BC_DEF,
    parameter int unsigned NUM_W  = NUM_W_DEF
);
    logic                       enq_valid;
    logic                       enq_ready;
    logic [PAY_W-1:0]           enq_payload;
    logic [NUM_W-1:0]           enq_num;
    logic [3*TAG_W-1:0]         enq_tag;
    logic [2:0]                 enq_rdy;
    logic [3*DATA_W-1:0]        enq_val;
    logic [NUM_BC-1:0]          bc_valid;
    logic [NUM_BC*TAG_W-1:0]    bc_tag;
    logic [NUM_BC*DATA_W-1:0]   bc_val;
    logic                       iss_valid;
    logic [PAY_W-1:0]           iss_payload;
    logic [NUM_W-1:0]           iss_num;
    logic [DATA_W-1:0]          iss_opa;
    logic [DATA_W-1:0]          iss_opb;
    logic [DATA_W-1:0]          iss_opc;
    logic [$clog2(DEPTH):0]     occupancy;
    logic                       issue_halt;

    modport master (
        output enq_valid, enq_payload, enq_num, enq_tag, enq_rdy, enq_val,
        output bc_valid, bc_tag, bc_val,
        input  enq_ready, iss_valid, iss_payload, iss_num, iss_opa, iss_opb, iss_opc,
        input  occupancy, issue_halt
    );

    modport slave (
        input  enq_valid, enq_payload, enq_num, enq_tag, enq_rdy, enq_val,
        input  bc_valid, bc_tag, bc_val,
        output enq_ready, iss_valid, iss_payload, iss_num, iss_opa, iss_opb, iss_opc,
        output occupancy, issue_halt
    );
endinterface

// File: rtl/iq_oldest_select.sv
// Age-matrix oldest-first picker: r_older[i][j] = 1 means entry j is older than entry i.
module iq_oldest_select
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             i_enq_en,
    input  logic [IDX_W-1:0] i_enq_idx,
    input  logic [DEPTH-1:0] i_valid,
    input  logic [DEPTH-1:0] i_free,
    input  logic [DEPTH-1:0] i_eligible,
    output logic [DEPTH-1:0] o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any
);
    logic [DEPTH-1:0] r_older [DEPTH];

    // Row set from live entries on enqueue; column cleared when an entry frees.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
        end else if (FLUSH) begin
            for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) r_older[i] <= r_older[i] & ~i_free;
            if (i_enq_en) r_older[i_enq_idx] <= i_valid & ~i_free;
        end
    end

    // Grant the eligible entry that has no older eligible entry.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_grant[i] = i_eligible[i] && ((r_older[i] & i_eligible) == '0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (o_grant[i]) o_grant_idx = IDX_W'(i);
        end
        o_any = |o_grant;
    end
endmodule

// File: rtl/issue_queue_param.sv
// Out-of-order issue queue: tag wakeup from broadcast ports, oldest-ready-first issue.
module issue_queue_param
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PAY_W  = PAY_W_DEF,
    parameter int unsigned NUM_BC = NUM_BC_DEF,
    parameter int unsigned NUM_W  = NUM_W_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic STALL,
    input  logic FLUSH,
    issue_queue_param_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = IDX_W + 1;

    logic [DEPTH-1:0]   r_valid;
    logic [PAY_W-1:0]   r_payload [DEPTH];
    logic [NUM_W-1:0]   r_num     [DEPTH];
    logic [TAG_W-1:0]   r_tag     [DEPTH][NUM_SRC];
    logic [NUM_SRC-1:0] r_rdy     [DEPTH];
    logic [DATA_W-1:0]  r_val     [DEPTH][NUM_SRC];
    logic [OCC_W-1:0]   r_occ;
    logic               r_iss_valid;
    logic [PAY_W-1:0]   r_iss_payload;
    logic [NUM_W-1:0]   r_iss_num;
    logic [DATA_W-1:0]  r_iss_op [NUM_SRC];

    logic [DATA_W:0]    w_wake [DEPTH][NUM_SRC];
    logic [NUM_SRC-1:0] w_enq_rdy;
    logic [DATA_W-1:0]  w_enq_v [NUM_SRC];
    logic [IDX_W-1:0]   w_free_idx;
    logic [DEPTH-1:0]   w_elig;
    logic [DEPTH-1:0]   w_grant;
    logic [DEPTH-1:0]   w_free_mask;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_any;
    logic               w_enq_ready;
    logic               w_enq_fire;
    logic               w_iss_fire;

    // Returns {hit, value}; scanning high to low lets the lowest matching port win.
    function automatic logic [DATA_W:0] bc_lookup(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_BC-1:0]         v,
        input logic [NUM_BC*TAG_W-1:0]   t,
        input logic [NUM_BC*DATA_W-1:0]  d
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int p = NUM_BC - 1; p >= 0; p--) begin
            if (v[p] && (tag != '0) && (t[p*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, d[p*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    // Wakeup matches, rename-time source resolution, free slot and handshake.
    always_comb begin
        logic [TAG_W-1:0] w_t;
        logic [DATA_W:0]  w_byp;
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                w_wake[i][s] = bc_lookup(r_tag[i][s], bus.bc_valid, bus.bc_tag, bus.bc_val);
            end
            w_elig[i] = r_valid[i] && (&r_rdy[i]);
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            w_t   = bus.enq_tag[s*TAG_W +: TAG_W];
            w_byp = bc_lookup(w_t, bus.bc_valid, bus.bc_tag, bus.bc_val);
            if (w_t == '0) begin
                w_enq_rdy[s] = 1'b1;
                w_enq_v[s]   = '0;
            end else if (bus.enq_rdy[s]) begin
                w_enq_rdy[s] = 1'b1;
                w_enq_v[s]   = bus.enq_val[s*DATA_W +: DATA_W];
            end else begin
                w_enq_rdy[s] = w_byp[DATA_W];
                w_enq_v[s]   = w_byp[DATA_W-1:0];
            end
        end
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = IDX_W'(i);
        end
        w_enq_ready = (r_occ < OCC_W'(DEPTH));
        w_enq_fire  = bus.enq_valid && w_enq_ready && !STALL && !FLUSH;
        w_iss_fire  = w_any && !STALL && !FLUSH;
        w_free_mask = w_iss_fire ? w_grant : '0;
    end

    iq_oldest_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .CLK         (CLK),
        .RESET       (RESET),
        .FLUSH       (FLUSH),
        .i_enq_en    (w_enq_fire),
        .i_enq_idx   (w_free_idx),
        .i_valid     (r_valid),
        .i_free      (w_free_mask),
        .i_eligible  (w_elig),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_any       (w_any)
    );

    // Entry storage, wakeup capture (also under STALL), issue register and occupancy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_valid       <= '0;
            r_occ         <= '0;
            r_iss_valid   <= 1'b0;
            r_iss_payload <= '0;
            r_iss_num     <= '0;
            for (int s = 0; s < NUM_SRC; s++) r_iss_op[s] <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_payload[i] <= '0;
                r_num[i]     <= '0;
                r_rdy[i]     <= '0;
                for (int s = 0; s < NUM_SRC; s++) begin
                    r_tag[i][s] <= '0;
                    r_val[i][s] <= '0;
                end
            end
        end else if (FLUSH) begin
            r_valid       <= '0;
            r_occ         <= '0;
            r_iss_valid   <= 1'b0;
            r_iss_payload <= '0;
            r_iss_num     <= '0;
            for (int s = 0; s < NUM_SRC; s++) r_iss_op[s] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (r_valid[i] && !r_rdy[i][s] && w_wake[i][s][DATA_W]) begin
                        r_rdy[i][s] <= 1'b1;
                        r_val[i][s] <= w_wake[i][s][DATA_W-1:0];
                    end
                end
            end
            if (!STALL) begin
                r_iss_valid <= w_any;
                if (w_any) begin
                    r_valid[w_gidx] <= 1'b0;
                    r_iss_payload   <= r_payload[w_gidx];
                    r_iss_num       <= r_num[w_gidx];
                    for (int s = 0; s < NUM_SRC; s++) r_iss_op[s] <= r_val[w_gidx][s];
                end else begin
                    r_iss_payload <= '0;
                    r_iss_num     <= '0;
                    for (int s = 0; s < NUM_SRC; s++) r_iss_op[s] <= '0;
                end
                if (w_enq_fire) begin
                    r_valid[w_free_idx]   <= 1'b1;
                    r_payload[w_free_idx] <= bus.enq_payload;
                    r_num[w_free_idx]     <= bus.enq_num;
                    r_rdy[w_free_idx]     <= w_enq_rdy;
                    for (int s = 0; s < NUM_SRC; s++) begin
                        r_tag[w_free_idx][s] <= bus.enq_tag[s*TAG_W +: TAG_W];
                        r_val[w_free_idx][s] <= w_enq_v[s];
                    end
                end
                r_occ <= r_occ + OCC_W'(w_enq_fire) - OCC_W'(w_iss_fire);
            end
        end
    end

    assign bus.enq_ready   = w_enq_ready;
    assign bus.issue_halt  = !w_enq_ready;
    assign bus.occupancy   = r_occ;
    assign bus.iss_valid   = r_iss_valid;
    assign bus.iss_payload = r_iss_payload;
    assign bus.iss_num     = r_iss_num;
    assign bus.iss_opa     = r_iss_op[SRC_A];
    assign bus.iss_opb     = r_iss_op[SRC_B];
    assign bus.iss_opc     = r_iss_op[SRC_C];
endmodule

// File: tb/tb_issue_queue_param.sv
// Directed bench for issue_queue_param with hand-computed expectations.
module tb_issue_queue_param;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic stall = 1'b0;
    logic flush = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    issue_queue_param_if bus_if ();

    issue_queue_param dut (
        .CLK   (clk),
        .RESET (rst),
        .STALL (stall),
        .FLUSH (flush),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction: source A carries the tag under test, B and C use tag 0.
    task automatic enq(input logic [105:0] p, input logic [5:0] ta, input logic ra);
        bus_if.enq_valid   = 1'b1;
        bus_if.enq_payload = p;
        bus_if.enq_num     = 32'(p) + 32'h1000;
        bus_if.enq_tag     = {6'd0, 6'd0, ta};
        bus_if.enq_rdy     = {2'b00, ra};
        bus_if.enq_val     = {96{1'b1}};
    endtask

    task automatic enq_clear();
        bus_if.enq_valid = 1'b0;
    endtask

    task automatic bc(input int port, input logic [5:0] t, input logic [31:0] v);
        bus_if.bc_valid[port]          = 1'b1;
        bus_if.bc_tag[port*6 +: 6]     = t;
        bus_if.bc_val[port*32 +: 32]   = v;
    endtask

    task automatic bc_clear();
        bus_if.bc_valid = '0;
    endtask

    initial begin
        bus_if.enq_valid   = 1'b0;
        bus_if.enq_payload = '0;
        bus_if.enq_num     = '0;
        bus_if.enq_tag     = '0;
        bus_if.enq_rdy     = '0;
        bus_if.enq_val     = '0;
        bus_if.bc_valid    = '0;
        bus_if.bc_tag      = '0;
        bus_if.bc_val      = '0;

        // Reset state
        tick();
        tick();
        check("rst_iss_valid", 128'(bus_if.iss_valid), 128'd0);
        check("rst_occ", 128'(bus_if.occupancy), 128'd0);
        check("rst_enq_ready", 128'(bus_if.enq_ready), 128'd1);
        check("rst_halt", 128'(bus_if.issue_halt), 128'd0);
        rst = 1'b0;

        // All-zero-tag instruction issues one edge after enqueue with zero operands
        enq(106'h5, 6'd0, 1'b0);
        tick();
        enq_clear();
        check("s1_occ_after_enq", 128'(bus_if.occupancy), 128'd1);
        check("s1_no_early_issue", 128'(bus_if.iss_valid), 128'd0);
        tick();
        check("s1_iss_valid", 128'(bus_if.iss_valid), 128'd1);
        check("s1_payload", 128'(bus_if.iss_payload), 128'h5);
        check("s1_num", 128'(bus_if.iss_num), 128'h1005);
        check("s1_opa", 128'(bus_if.iss_opa), 128'd0);
        check("s1_opc", 128'(bus_if.iss_opc), 128'd0);
        check("s1_occ_after_iss", 128'(bus_if.occupancy), 128'd0);
        tick();
        check("s1_idle_valid", 128'(bus_if.iss_valid), 128'd0);
        check("s1_idle_payload", 128'(bus_if.iss_payload), 128'd0);

        // Wakeup two cycles later; both ports match tag 7, port 0 must win
        enq(106'h22, 6'd7, 1'b0);
        tick();
        enq_clear();
        tick();
        check("s2_waiting", 128'(bus_if.iss_valid), 128'd0);
        bc(0, 6'd7, 32'h1234);
        bc(1, 6'd7, 32'h9999);
        tick();
        bc_clear();
        check("s2_wake_edge_no_issue", 128'(bus_if.iss_valid), 128'd0);
        tick();
        check("s2_iss_valid", 128'(bus_if.iss_valid), 128'd1);
        check("s2_payload", 128'(bus_if.iss_payload), 128'h22);
        check("s2_opa_port0_wins", 128'(bus_if.iss_opa), 128'h1234);

        // Same-cycle bypass from bc1
        enq(106'h33, 6'd9, 1'b0);
        bc(1, 6'd9, 32'hAB);
        tick();
        enq_clear();
        bc_clear();
        check("s3_occ", 128'(bus_if.occupancy), 128'd1);
        tick();
        check("s3_iss_valid", 128'(bus_if.iss_valid), 128'd1);
        check("s3_opa_bypass", 128'(bus_if.iss_opa), 128'hAB);

        // I0 waits, I1 ready at rename: I1 first, then I0 once woken
        enq(106'h40, 6'd12, 1'b0);
        tick();
        enq(106'h41, 6'd5, 1'b1);
        tick();
        enq_clear();
        bc(0, 6'd12, 32'h77);
        tick();
        bc_clear();
        check("s4_first_payload", 128'(bus_if.iss_payload), 128'h41);
        check("s4_first_opa_renamed", 128'(bus_if.iss_opa), 128'hFFFF_FFFF);
        tick();
        check("s4_second_payload", 128'(bus_if.iss_payload), 128'h40);
        check("s4_second_opa", 128'(bus_if.iss_opa), 128'h77);

        // Age order across slot reuse: W reuses slot 0 but is younger than Z
        enq(106'h80, 6'd20, 1'b0);
        tick();
        enq(106'h81, 6'd21, 1'b0);
        tick();
        enq(106'h82, 6'd22, 1'b0);
        tick();
        enq_clear();
        bc(0, 6'd20, 32'h1);
        tick();
        bc_clear();
        tick();
        check("age_x_payload", 128'(bus_if.iss_payload), 128'h80);
        check("age_occ2", 128'(bus_if.occupancy), 128'd2);
        enq(106'h83, 6'd23, 1'b0);
        tick();
        enq_clear();
        bc(0, 6'd23, 32'h3);
        bc(1, 6'd22, 32'h2);
        tick();
        bc_clear();
        tick();
        check("age_z_before_w", 128'(bus_if.iss_payload), 128'h82);
        tick();
        check("age_w_next", 128'(bus_if.iss_payload), 128'h83);
        bc(0, 6'd21, 32'h4);
        tick();
        bc_clear();
        tick();
        check("age_y_last", 128'(bus_if.iss_payload), 128'h81);
        tick();
        check("age_empty", 128'(bus_if.occupancy), 128'd0);

        // Fill all 16 entries; entry 0 waits on 29, the rest on 30
        for (int i = 0; i < 16; i++) begin
            enq(106'(32'h100 + i), (i == 0) ? 6'd29 : 6'd30, 1'b0);
            tick();
        end
        check("full_occ", 128'(bus_if.occupancy), 128'd16);
        check("full_enq_ready", 128'(bus_if.enq_ready), 128'd0);
        check("full_halt", 128'(bus_if.issue_halt), 128'd1);
        enq(106'h77, 6'd0, 1'b0);
        bc(0, 6'd29, 32'h5);
        tick();
        bc_clear();
        check("full_enq_refused", 128'(bus_if.occupancy), 128'd16);
        tick();
        check("full_issue_payload", 128'(bus_if.iss_payload), 128'h100);
        check("full_occ_after_free", 128'(bus_if.occupancy), 128'd15);
        check("full_ready_next", 128'(bus_if.enq_ready), 128'd1);
        tick();
        enq_clear();
        check("full_refill_occ", 128'(bus_if.occupancy), 128'd16);
        check("full_refill_no_issue", 128'(bus_if.iss_valid), 128'd0);
        tick();
        check("full_refill_issue", 128'(bus_if.iss_payload), 128'h77);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("full_flush_occ", 128'(bus_if.occupancy), 128'd0);

        // STALL 3 cycles; wakeup on tag 4 mid-stall must not be lost
        enq(106'h50, 6'd4, 1'b0);
        tick();
        stall = 1'b1;
        enq(106'h51, 6'd0, 1'b0);
        tick();
        check("stall_c1_no_issue", 128'(bus_if.iss_valid), 128'd0);
        check("stall_c1_no_enq", 128'(bus_if.occupancy), 128'd1);
        bc(0, 6'd4, 32'h44);
        tick();
        bc_clear();
        check("stall_c2_no_issue", 128'(bus_if.iss_valid), 128'd0);
        tick();
        check("stall_c3_no_issue", 128'(bus_if.iss_valid), 128'd0);
        check("stall_c3_occ", 128'(bus_if.occupancy), 128'd1);
        stall = 1'b0;
        enq_clear();
        tick();
        check("stall_release_issue", 128'(bus_if.iss_valid), 128'd1);
        check("stall_release_payload", 128'(bus_if.iss_payload), 128'h50);
        check("stall_release_opa", 128'(bus_if.iss_opa), 128'h44);

        // STALL holds a live issue register
        stall = 1'b1;
        tick();
        check("stall_hold_valid", 128'(bus_if.iss_valid), 128'd1);
        check("stall_hold_payload", 128'(bus_if.iss_payload), 128'h50);
        stall = 1'b0;
        tick();

        // FLUSH with 10 entries and a simultaneous enqueue that must be dropped
        for (int i = 0; i < 10; i++) begin
            enq(106'(32'h200 + i), 6'd30, 1'b0);
            tick();
        end
        check("flush_pre_occ", 128'(bus_if.occupancy), 128'd10);
        flush = 1'b1;
        stall = 1'b1;
        enq(106'h61, 6'd0, 1'b0);
        tick();
        flush = 1'b0;
        stall = 1'b0;
        enq_clear();
        check("flush_occ", 128'(bus_if.occupancy), 128'd0);
        check("flush_iss_valid", 128'(bus_if.iss_valid), 128'd0);
        tick();
        check("flush_enq_dropped", 128'(bus_if.iss_valid), 128'd0);
        check("flush_occ_stays", 128'(bus_if.occupancy), 128'd0);

        // Reset mid-operation clears immediately; first enqueue after accepted
        enq(106'h90, 6'd30, 1'b0);
        tick();
        enq(106'h91, 6'd30, 1'b0);
        tick();
        enq_clear();
        rst = 1'b1;
        #1;
        check("midrst_occ", 128'(bus_if.occupancy), 128'd0);
        check("midrst_ready", 128'(bus_if.enq_ready), 128'd1);
        tick();
        rst = 1'b0;
        enq(106'h70, 6'd0, 1'b0);
        tick();
        enq_clear();
        check("postrst_enq", 128'(bus_if.occupancy), 128'd1);
        tick();
        check("postrst_issue", 128'(bus_if.iss_payload), 128'h70);
        check("postrst_occ", 128'(bus_if.occupancy), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
